// File: rtl/huffman_stream_encoder_if.sv
`default_nettype none
// ============================================================================
// Module  : huffman_stream_encoder_if
// Purpose : Table-write, symbol-in and packed-word-out bundle of the encoder.
// Revision: 1.0
// ============================================================================
interface huffman_stream_encoder_if #(
    parameter int OUT_W      = 32,
    parameter int MAX_CODE   = 16,
    parameter int NUM_TABLES = 2
) ();
    localparam int TW = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
    localparam int AW = $clog2(NUM_TABLES) + 8;
    localparam int NW = $clog2(OUT_W + 1);

    logic                  tbl_we;
    logic [AW-1:0]         tbl_waddr;
    logic [5+MAX_CODE-1:0] tbl_wdata;
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            in_sym;
    logic [10:0]           in_amp;
    logic [TW-1:0]         in_tbl;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic                  out_last;
    logic [NW-1:0]         out_nbits;

    modport master (
        output tbl_we, tbl_waddr, tbl_wdata,
        output in_valid, in_sym, in_amp, in_tbl, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_nbits
    );

    modport slave (
        input  tbl_we, tbl_waddr, tbl_wdata,
        input  in_valid, in_sym, in_amp, in_tbl, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_nbits
    );
endinterface
`default_nettype wire

// File: rtl/huffman_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module  : huffman_stream_encoder
// Purpose : Table-driven Huffman encoder packing code+amplitude bits MSB-first.
// Revision: 1.0
// ============================================================================
module huffman_stream_encoder #(
    parameter int OUT_W      = 32,
    parameter int MAX_CODE   = 16,
    parameter int NUM_TABLES = 2
) (
    input  wire logic                clk_in,
    input  wire logic                rst_in,
    huffman_stream_encoder_if.slave  bus,
    output logic                     busy,
    output logic                     err_size
);
    localparam int c_BW = 2 * OUT_W;
    localparam int c_FW = $clog2(c_BW + 1);
    localparam int c_CW = MAX_CODE + 11;
    localparam int c_AW = $clog2(NUM_TABLES) + 8;
    localparam int c_EW = 5 + MAX_CODE;
    localparam int c_NW = $clog2(OUT_W + 1);
    localparam logic [c_FW-1:0] c_OUTW_F = c_FW'(OUT_W);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    logic [c_EW-1:0]     r_tbl [0:(1<<c_AW)-1];
    logic [c_AW-1:0]     w_raddr;
    logic                w_accept, w_size_bad;
    logic                r_s1_valid, r_s1_last, r_err;
    logic [4:0]          r_s1_len;
    logic [MAX_CODE-1:0] r_s1_code;
    logic [3:0]          r_s1_size;
    logic [10:0]         r_s1_amp;
    logic [c_BW-1:0]     r_buf, w_buf_shift, w_app;
    logic [c_FW-1:0]     r_fill, w_pop_n, w_base, w_sh;
    logic [5:0]          w_s1_n;
    logic [c_CW-1:0]     w_code, w_amp, w_chunk;
    logic [1:0]          r_state, w_state_nx;
    logic                w_flushing, w_hold, w_word, w_done, w_pop;

    generate
        if (NUM_TABLES > 1) begin : g_addr_multi
            assign w_raddr = {bus.in_tbl, bus.in_sym};
        end else begin : g_addr_single
            assign w_raddr = bus.in_sym;
        end
    endgenerate

    // Table RAM survives reset so tables need programming only once.
    always_ff @(posedge clk_in) begin
        if (bus.tbl_we) r_tbl[bus.tbl_waddr] <= bus.tbl_wdata;
    end

    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_size_bad = bus.in_sym[3:0] > 4'd11;
    assign err_size   = r_err;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_len   <= '0;
            r_s1_code  <= '0;
            r_s1_size  <= '0;
            r_s1_amp   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                {r_s1_len, r_s1_code} <= r_tbl[w_raddr];
                r_s1_size <= w_size_bad ? 4'd0 : bus.in_sym[3:0];
                r_s1_amp  <= bus.in_amp;
                r_s1_last <= bus.in_last;
                if (w_size_bad) r_err <= 1'b1;
            end
        end
    end

    assign w_s1_n  = r_s1_valid ? (6'(r_s1_len) + 6'(r_s1_size)) : 6'd0;
    assign w_code  = c_CW'(r_s1_code) & ~({c_CW{1'b1}} << r_s1_len);
    assign w_amp   = c_CW'(r_s1_amp)  & ~({c_CW{1'b1}} << r_s1_size);
    assign w_chunk = r_s1_valid ? ((w_code << r_s1_size) | w_amp) : '0;

    // A full word is held back while the final symbol is still in stage 1,
    // so a stream ending on a word boundary tags that word as last.
    assign w_hold = r_s1_valid && r_s1_last;
    assign w_word = (r_fill > c_OUTW_F) || ((r_fill == c_OUTW_F) && !w_hold);
    assign w_done = w_flushing && (r_fill <= c_OUTW_F);

    assign bus.out_valid = w_word || w_done;
    assign bus.out_last  = w_done;
    assign bus.out_nbits = (r_fill >= c_OUTW_F) ? c_NW'(OUT_W) : c_NW'(r_fill);
    assign bus.out_data  = r_buf[c_BW-1 -: OUT_W] |
                           (w_done ? ({OUT_W{1'b1}} >> r_fill) : {OUT_W{1'b0}});
    assign bus.in_ready  = rst_in && !w_flushing && !w_hold &&
                           ((r_fill + c_FW'(w_s1_n)) < c_OUTW_F);

    assign w_pop       = bus.out_valid && bus.out_ready;
    assign w_pop_n     = !w_pop ? '0 : ((r_fill >= c_OUTW_F) ? c_OUTW_F : r_fill);
    assign w_base      = r_fill - w_pop_n;
    assign w_sh        = c_FW'(c_BW) - w_base - c_FW'(w_s1_n);
    assign w_buf_shift = w_pop ? (r_buf << OUT_W) : r_buf;
    assign w_app       = {{(c_BW-c_CW){1'b0}}, w_chunk} << w_sh;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else begin
            r_buf  <= w_buf_shift | w_app;
            r_fill <= w_base + c_FW'(w_s1_n);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) r_state <= c_ST_IDLE;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept) w_state_nx = c_ST_RUN;
            c_ST_RUN:   if (r_s1_valid && r_s1_last) w_state_nx = c_ST_FLUSH;
            c_ST_FLUSH: if (w_pop && bus.out_last) w_state_nx = c_ST_IDLE;
            default:    w_state_nx = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_flushing = (r_state == c_ST_FLUSH);
        busy       = (r_state != c_ST_IDLE);
    end
endmodule
`default_nettype wire

// File: doc/huffman_stream_encoder.md
Name: huffman_stream_encoder

Overview:
- Streaming, table-driven Huffman encoder and bit packer that generalises the array-based encoder.
- Accepts one {run,size} symbol plus amplitude bits per handshake. Looks up the code in one of NUM_TABLES programmable tables (e.g. luma/chroma).
- Appends the code, then the amplitude bits, MSB-first into a bit buffer and emits packed OUT_W-bit words.
- Sits between the run-length stage and the output bitstream writer.

Parameters:
- OUT_W, 32, output word width; legal values 32 or 64 (must be ≥ MAX_CODE+11).
- MAX_CODE, 16, maximum Huffman code length in bits.
- NUM_TABLES, 2, number of independent code tables; ≥1.

Ports:
- clk_in  input  1  clock; all logic on the rising edge.
- rst_in  input  1  synchronous, active-low reset.
- tbl_we  input  1  table write strobe.
- tbl_waddr  input  $clog2(NUM_TABLES)+8  {table index, symbol}.
- tbl_wdata  input  5+MAX_CODE  {len[4:0], code[MAX_CODE-1:0]}; code right-aligned.
- in_valid  input  1  symbol valid.
- in_ready  output  1  symbol accepted when in_valid && in_ready.
- in_sym  input  8  {run[3:0], size[3:0]}.
- in_amp  input  11  amplitude; low `size` bits used.
- in_tbl  input  max(1,$clog2(NUM_TABLES))  table select.
- in_last  input  1  final symbol of the stream.
- out_valid  output  1  word valid.
- out_ready  input  1  word accepted when out_valid && out_ready.
- out_data  output  OUT_W  packed bits; first bit in the MSB.
- out_last  output  1  word holds the final data bit of the stream.
- out_nbits  output  $clog2(OUT_W+1)  meaningful bits in out_data; OUT_W except on the last word.
- busy  output  1  stream in progress (symbol accepted, last word not yet taken).
- err_size  output  1  sticky: a symbol with size > 11 was accepted.

Behaviour:
- Reset (rst_in=0 at a clock edge): out_valid=0, out_data=0, out_last=0, out_nbits=0, busy=0, err_size=0, in_ready=0 while in reset.
  - Bit buffer fill and pipeline valid bits are cleared.
  - Table RAM is NOT cleared.
  - Reset mid-stream discards all buffered bits and the pending word. in_ready=1 on the first cycle after release.
- Table writes: take effect on the next clock edge and are legal at any time. A write and a lookup of the same entry in the same cycle returns the old entry.
- len=0 entry: contributes no code bits; amplitude bits are still appended.
- Stage 1 (acceptance cycle): register the table entry {len, code}, size (sizes 12–15 treated as 0 and err_size set), amp, last.
- Stage 2 (next cycle): append code[len-1:0] then amp[size-1:0] to the bit buffer (width 2*OUT_W); fill += len+size.
- Latency: a symbol that completes a word makes out_valid high 2 cycles after acceptance.
- Output: out_valid=1 whenever fill ≥ OUT_W, or the flush word is ready.
  - out_data = the oldest OUT_W bits; these are stable while out_valid && !out_ready.
  - On handshake, the buffer shifts by OUT_W.
  - A stage-2 append and a word removal in the same cycle are both applied.
- Backpressure: in_ready = !flushing && (fill + pending stage-1 len+size) < OUT_W. This guarantees fill never exceeds OUT_W+MAX_CODE+11 ≤ 2*OUT_W; no bit is ever dropped.
- Flush: after the in_last symbol is appended, flushing=1 and in_ready=0.
  - Remaining bits (1..OUT_W-1) are emitted as one word, padded at the LSB end with 1s: out_nbits = remaining bits, out_last=1.
  - If the stream ends exactly on a word boundary, that full word carries out_last=1 with out_nbits=OUT_W; no padding word is sent.
  - If the whole stream produced zero bits, one word of all 1s is sent with out_nbits=0, out_last=1.
- Flush completion: flushing and busy clear on the out_last handshake. in_ready returns the next cycle.
- busy: set on the first accepted symbol, cleared as above.
- err_size: cleared only by reset.

Test Plan:
- Table0[0x01]={2,2'b00}; send sym 0x01, amp 1, last=1 -> one word 0x3FFF_FFFF, out_nbits=3, out_last=1.
- Table0[0x00]={16,0xA5A5}; 16 symbols sym 0x00, size 0, out_ready=1, last on the 16th -> 8 words 0xA5A5_A5A5; only the 8th has out_last=1, out_nbits=32; throughput one symbol per cycle until in_ready throttles.
- Same stream with out_ready held 0 for 20 cycles -> in_ready drops, out_data stable; after release the identical 8 words arrive, no loss or duplication.
- Table0[0x22]={4,4'hA}, Table1[0x22]={3,3'b111}; send sym 0x22 amp 2'b01 using in_tbl=0 then in_tbl=1, last -> bits 1010 01 111 01, word 0xA7BF_FFFF, out_nbits=11.
- Sym with size=13 -> err_size=1 and stays 1; no amplitude bits appended.
- Assert rst_in=0 for one cycle while a flush word is pending -> out_valid=0, busy=0, err_size=0; a new stream afterwards reuses the programmed tables and matches the first scenario's output.
